mem_dump_ctrl: RTL
==================

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 Parameter DEPTH, 512, number of data-memory words dumped (>=2).
REQ-002 Parameter AW, 9, word-address width; 2**AW SHALL be >= DEPTH.
REQ-003 Parameter DRAIN, 4, pipeline-drain cycles after halt detect (>=1).
REQ-004 CLOCK  in  1  single clock; all state changes on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 Inst_D  in  32  instruction currently in the decode stage.
REQ-007 CPU_Stall  out  1  freezes PC / IF-ID update when high.
REQ-008 MemRdAddr  out  AW  word address to the data-memory read port.
REQ-009 MemRdData  in  32  data-memory read data, valid one cycle after MemRdAddr.
REQ-010 DumpValid  out  1  DumpData/DumpAddr hold a word for the consumer.
REQ-011 DumpReady  in  1  consumer accepts the word when high with DumpValid.
REQ-012 DumpData  out  32  dumped memory word.
REQ-013 DumpAddr  out  AW  word address of DumpData.
REQ-014 DumpDone  out  1  all DEPTH words transferred.

Function
REQ-015 The block SHALL be an FSM with states IDLE, DRAIN, READ, LATCH, OUT, DONE.
REQ-016 IDLE: Inst_D == 32'hFFFFFFFF SHALL move to DRAIN next edge, load drain counter with DRAIN-1, set CPU_Stall=1.
REQ-017 Halt pattern SHALL be ignored in every state other than IDLE.
REQ-018 DRAIN: counter decrements each cycle; when counter==0 SHALL go to READ with address counter=0, giving exactly DRAIN cycles in DRAIN.
REQ-019 READ: MemRdAddr SHALL equal the address counter; next state LATCH.
REQ-020 LATCH: MemRdData SHALL be registered into DumpData, address counter into DumpAddr; DumpValid=1 from the next cycle; next state OUT.
REQ-021 OUT: DumpValid, DumpData, DumpAddr SHALL stay stable while DumpReady=0.
REQ-022 OUT with DumpReady=1: transfer completes that edge; DumpValid=0 next cycle; if address==DEPTH-1 go DONE, else address+1 and go READ.
REQ-023 Peak throughput SHALL be one word per 3 cycles (READ, LATCH, OUT with ready high).
REQ-024 DONE: DumpDone=1, DumpValid=0, CPU_Stall=1, held until RESET.
REQ-025 CPU_Stall SHALL be 1 in every state except IDLE.
REQ-026 Address counter SHALL never exceed DEPTH-1; no wrap to 0 after the last word.
REQ-027 DumpReady while DumpValid=0 SHALL have no effect.

Reset
REQ-028 RESET=1 at an edge SHALL force IDLE from any state, mid-drain or mid-dump included, and override a simultaneous halt pattern.
REQ-029 Reset values: CPU_Stall=0, MemRdAddr=0, DumpValid=0, DumpData=0, DumpAddr=0, DumpDone=0, drain and address counters=0.
REQ-030 After RESET deasserts the block SHALL be ready to detect a new halt the next cycle.

Verification (DEPTH=4, DRAIN=4, memory word k = 32'hA0+k)
REQ-031 Inst_D=FFFFFFFF one cycle, DumpReady=1 -> CPU_Stall high next cycle, 4 DRAIN cycles, then words A0,A1,A2,A3 at DumpAddr 0..3, each 3 cycles apart, then DumpDone=1.
REQ-032 DumpReady=0 for 5 cycles on word 1 -> DumpValid=1, DumpData=A1, DumpAddr=1 stable all 5 cycles; exactly one transfer per word.
REQ-033 RESET pulsed during DumpAddr=2 -> all outputs zero next cycle; new halt restarts dump from address 0.
REQ-034 Halt pattern presented again during DRAIN and OUT -> no restart, drain length unchanged.
REQ-035 RESET and halt pattern in the same cycle -> IDLE, CPU_Stall=0 next cycle.
REQ-036 Inst_D=00000000 for 100 cycles from reset -> CPU_Stall, DumpValid, DumpDone remain 0.

Source files
------------

// File: rtl/mem_dump_ctrl.sv
// rtl/mem_dump_ctrl.sv - halt-triggered data-memory dump controller
// Stalls the CPU on a halt instruction, drains the pipeline, then streams every word out.
module mem_dump_ctrl #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DRAIN = 4
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [31:0]   Inst_D,
  output logic          CPU_Stall,
  output logic [AW-1:0] MemRdAddr,
  input  logic [31:0]   MemRdData,
  output logic          DumpValid,
  input  logic          DumpReady,
  output logic [31:0]   DumpData,
  output logic [AW-1:0] DumpAddr,
  output logic          DumpDone
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  localparam logic [31:0]   HALT_INST = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] DRAIN_TOP = DW'(DRAIN - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [31:0]   data_q,  data_d;
  logic [AW-1:0] daddr_q, daddr_d;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    addr_d  = addr_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    case (state_q)
      S_IDLE: begin
        if (Inst_D == HALT_INST) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_TOP;
        end
      end
      S_DRAIN: begin
        // Counter starts at DRAIN-1, so exactly DRAIN cycles are spent here.
        if (drain_q == '0) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // Read data returns one cycle after the address was presented in READ.
        data_d  = MemRdData;
        daddr_d = addr_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (DumpReady) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign CPU_Stall = (state_q != S_IDLE);
  assign MemRdAddr = addr_q;
  assign DumpValid = (state_q == S_OUT);
  assign DumpDone  = (state_q == S_DONE);
  assign DumpData  = data_q;
  assign DumpAddr  = daddr_q;

endmodule
